// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: fetch/decode/execute/mem/writeback sequencing.
// Optional illegal-opcode trap state enabled by `define ILLEGAL_TRAP_EN.
module multicycle_control_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     ir,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_zero,
    input  logic            dmem_ready,
    output logic            alu_src,
    output logic [1:0]      alu_op,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic [2:0]      state,
    output logic            instr_retired,
    output logic            trap
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic [31:0]     ir_q;

    logic is_r;
    logic is_i;
    logic is_ld;
    logic is_sd;
    logic is_beq;
    logic is_alu;
    logic is_mem;

    logic       req_c;
    logic       src_c;
    logic [1:0] op_c;
    logic       rw_c;
    logic       rd_c;
    logic       wr_c;
    logic       m2r_c;
    logic       ret_c;

    assign is_r   = ir_q[6:0] == OP_R;
    assign is_i   = ir_q[6:0] == OP_I;
    assign is_ld  = ir_q[6:0] == OP_LD;
    assign is_sd  = ir_q[6:0] == OP_SD;
    assign is_beq = ir_q[6:0] == OP_BEQ;
    assign is_alu = is_r | is_i;
    assign is_mem = is_ld | is_sd;

    // Branch target only applies to a taken BEQ; all else steps by 4.
    always_comb begin
        pc_next = pc_q + XLEN'(4);
        if (state_q == S_EXECUTE && is_beq && alu_zero)
            pc_next = pc_q + (imm << 1);
    end

    // State, instruction and PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && imem_ready)
                ir_q <= imem_rdata;
            if (ret_c)
                pc_q <= pc_next;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        src_c   = 1'b0;
        op_c    = 2'b00;
        rw_c    = 1'b0;
        rd_c    = 1'b0;
        wr_c    = 1'b0;
        m2r_c   = 1'b0;
        ret_c   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (imem_ready)
                    state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                src_c = is_i | is_mem;
                unique case (1'b1)
                    is_alu: begin
                        op_c    = 2'b10;
                        state_d = S_WB;
                    end
                    is_mem: state_d = S_MEM;
                    is_beq: begin
                        op_c    = 2'b01;
                        ret_c   = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        ret_c   = 1'b1;
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM: begin
                src_c = 1'b1;
                rd_c  = is_ld;
                wr_c  = is_sd;
                if (dmem_ready) begin
                    if (is_ld) begin
                        state_d = S_WB;
                    end else begin
                        ret_c   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rw_c    = 1'b1;
                m2r_c   = is_ld;
                src_c   = is_i | is_ld;
                op_c    = is_alu ? 2'b10 : 2'b00;
                ret_c   = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Reset forces every control low so an aborted access never lands.
    always_comb begin
        imem_req      = ~reset & req_c;
        alu_src       = ~reset & src_c;
        alu_op        = reset ? 2'b00 : op_c;
        reg_write     = ~reset & rw_c;
        mem_read      = ~reset & rd_c;
        mem_write     = ~reset & wr_c;
        mem_to_reg    = ~reset & m2r_c;
        instr_retired = ~reset & ret_c;
    end

    assign pc    = pc_q;
    assign ir    = ir_q;
    assign state = state_q;

`ifdef ILLEGAL_TRAP_EN
    logic trap_q;

    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)
            trap_q <= 1'b0;
        else if (state_d == S_TRAP)
            trap_q <= 1'b1;
    end

    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
// Per-cycle phase model built from instruction class and wait counts.
module tb_multicycle_control_unit;

    localparam int XLEN = 64;
    localparam logic [63:0] RST_PC = 64'h0;

    localparam int P_F = 0;
    localparam int P_D = 1;
    localparam int P_E = 2;
    localparam int P_M = 3;
    localparam int P_W = 4;
    localparam int P_T = 5;

    localparam int K_R   = 0;
    localparam int K_I   = 1;
    localparam int K_LD  = 2;
    localparam int K_SD  = 3;
    localparam int K_BEQ = 4;
    localparam int K_ILL = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [63:0] pc;
    logic [31:0] ir;
    logic [63:0] imm;
    logic        alu_zero;
    logic        dmem_ready;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [2:0]  state;
    logic        instr_retired;
    logic        trap;

    int ncmp  = 0;
    int nfail = 0;
    logic [63:0] model_pc;

    multicycle_control_unit #(
        .XLEN(XLEN), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .pc(pc), .ir(ir),
        .imm(imm), .alu_zero(alu_zero),
        .dmem_ready(dmem_ready), .alu_src(alu_src),
        .alu_op(alu_op), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .state(state),
        .instr_retired(instr_retired), .trap(trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int kind_of(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_SD;
            7'b1100011: return K_BEQ;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic [12:0] obs_ctl();
        return {state, imem_req, mem_read, mem_write,
                reg_write, mem_to_reg, alu_op, alu_src,
                instr_retired, trap};
    endfunction

    // Expected controls for one cycle, from the class/phase rules.
    function automatic logic [12:0] exp_ctl(input int p,
                                            input int k,
                                            input bit last);
        bit arith = (k == K_R) || (k == K_I);
        bit srck  = (k == K_I) || (k == K_LD) || (k == K_SD);
        bit act   = (p == P_E) || (p == P_M) || (p == P_W);
        logic [1:0] op = 2'b00;
        if ((p == P_E || p == P_W) && arith) op = 2'b10;
        if (p == P_E && k == K_BEQ) op = 2'b01;
        return {3'(p),
                p == P_F,
                p == P_M && k == K_LD,
                p == P_M && k == K_SD,
                p == P_W,
                p == P_W && k == K_LD,
                op,
                act && srck,
                last,
                p == P_T};
    endfunction

    task automatic run_instr(input logic [31:0] instr,
                             input logic [63:0] im,
                             input logic zb,
                             input int fw,
                             input int mw);
        int k = kind_of(instr[6:0]);
        int ph[$];
        int fi = 0;
        int mi = 0;
        bit trapped = 1'b0;
        for (int i = 0; i <= fw; i++) ph.push_back(P_F);
        ph.push_back(P_D);
        ph.push_back(P_E);
        if (k == K_LD || k == K_SD)
            for (int i = 0; i <= mw; i++) ph.push_back(P_M);
        if (k == K_R || k == K_I || k == K_LD)
            ph.push_back(P_W);
`ifdef ILLEGAL_TRAP_EN
        if (k == K_ILL) begin
            trapped = 1'b1;
            for (int i = 0; i < 3; i++) ph.push_back(P_T);
        end
`endif
        for (int c = 0; c < ph.size(); c++) begin
            int p = ph[c];
            imm        = im;
            alu_zero   = zb;
            imem_ready = (p == P_F) && (fi == fw);
            imem_rdata = imem_ready ? instr : $urandom;
            dmem_ready = (p == P_M) && (mi == mw);
            if (p == P_F) fi++;
            if (p == P_M) mi++;
            #1;
            check("ctl", 64'(obs_ctl()),
                  64'(exp_ctl(p, k,
                      !trapped && c == ph.size() - 1)));
            check("pc", pc, model_pc);
            if (p != P_F) check("ir", 64'(ir), 64'(instr));
            @(negedge clk);
        end
        if (trapped) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            model_pc = RST_PC;
        end else if (k == K_BEQ && zb) begin
            model_pc = model_pc + (im << 1);
        end else begin
            model_pc = model_pc + 64'd4;
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op);
        logic [31:0] r = $urandom;
        return {r[31:7], op};
    endfunction

    initial begin
        logic [63:0] diff;
        logic [6:0]  ops [6];
        logic [6:0]  ills [3];
        ops[0] = 7'b0110011; ops[1] = 7'b0010011;
        ops[2] = 7'b0000011; ops[3] = 7'b0100011;
        ops[4] = 7'b1100011; ops[5] = 7'b1111111;
        ills[0] = 7'b1111111; ills[1] = 7'b0110111;
        ills[2] = 7'b0000000;

        reset = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        imem_rdata = '0; imm = '0; alu_zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_state", 64'(state), 64'd0);
        check("rst_pc", pc, RST_PC);
        check("rst_ir", 64'(ir), 64'd0);
        check("rst_ctl", 64'(obs_ctl()), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_req", 64'(imem_req), 64'd1);
        @(negedge clk);
        model_pc = RST_PC;

        run_instr(32'h002081B3, 64'd0, 1'b0, 0, 0);
        check("r_pc4", pc, 64'h4);
        run_instr(32'h0000B103, 64'd0, 1'b0, 0, 3);
        run_instr(32'h00108093, 64'd0, 1'b0, 1, 0);
        run_instr(32'h0020B023, 64'd0, 1'b0, 0, 0);
        check("pc_10", pc, 64'h10);
        run_instr(32'h00000063, 64'd8, 1'b1, 0, 0);
        check("beq_taken", pc, 64'h20);
        run_instr(32'h00000063, -64'sd8, 1'b1, 0, 0);
        check("beq_back", pc, 64'h10);
        run_instr(32'h00000063, 64'd8, 1'b0, 0, 0);
        check("beq_not", pc, 64'h14);

        diff = 64'hFFFF_FFFF_FFFF_FFFC - model_pc;
        run_instr(32'h00000063, {1'b0, diff[63:1]}, 1'b1, 0, 0);
        check("pc_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        run_instr(32'h002081B3, 64'd0, 1'b0, 2, 0);
        check("pc_wrap", pc, 64'h0);

        run_instr(32'h0000007F, 64'd0, 1'b0, 0, 0);

        imem_rdata = 32'h0020B023; imem_ready = 1'b1;
        dmem_ready = 1'b0;
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("sd_mem", 64'(mem_write), 64'd1);
        @(negedge clk);
        reset = 1'b1; dmem_ready = 1'b1;
        #1;
        check("abort_wr", 64'(mem_write), 64'd0);
        check("abort_ret", 64'(instr_retired), 64'd0);
        @(negedge clk);
        reset = 1'b0; dmem_ready = 1'b0;
        #1;
        check("abort_st", 64'(state), 64'd0);
        check("abort_pc", pc, RST_PC);
        check("abort_ir", 64'(ir), 64'd0);
        check("abort_wr2", 64'(mem_write), 64'd0);
        check("abort_ret2", 64'(instr_retired), 64'd0);
        @(negedge clk);
        model_pc = RST_PC;

        for (int n = 0; n < 60; n++) begin
            int sel;
            logic [6:0] op;
`ifdef ILLEGAL_TRAP_EN
            sel = $urandom_range(0, 4);
`else
            sel = $urandom_range(0, 5);
`endif
            op = ops[sel];
            if (sel == 5) op = ills[$urandom_range(0, 2)];
            run_instr(mk(op), {$urandom, $urandom},
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 3),
                      $urandom_range(0, 3));
        end
        check("final_pc", pc, model_pc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter XLEN, default 64: datapath and PC width.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req / imem_ready  output / input  1 / 1  instruction-fetch request and completion.
REQ-006 imem_rdata  input  32  fetched instruction, valid when imem_ready=1.
REQ-007 pc  output  XLEN  current instruction address.
REQ-008 ir  output  32  latched instruction register.
REQ-009 imm  input  XLEN  sign-extended immediate decoded from ir.
REQ-010 alu_zero  input  1  ALU zero flag.
REQ-011 dmem_ready  input  1  data-memory access complete.
REQ-012 alu_src, alu_op[1:0], reg_write, mem_read, mem_write, mem_to_reg  output  1/2/1/1/1/1  datapath controls.
REQ-013 state  output  3  current FSM state encoding; instr_retired  output  1  one-cycle retire pulse.
REQ-014 trap  output  1  illegal-instruction indication (only with ILLEGAL_TRAP_EN).

Function
REQ-015 States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5.
- FETCH: imem_req=1 until imem_ready; on imem_ready, ir<=imem_rdata, go to DECODE.
- DECODE: one cycle, unconditional to EXECUTE.
REQ-016 Supported opcodes: R 0110011, I-ALU 0010011, LD 0000011, SD 0100011, BEQ 1100011.
REQ-017 EXECUTE: R/I-ALU -> WRITEBACK; LD/SD -> MEM; BEQ -> FETCH.
REQ-018 MEM: mem_read (LD) or mem_write (SD) held high until dmem_ready; then LD -> WRITEBACK, SD -> FETCH.
REQ-019 WRITEBACK: reg_write=1 for exactly one cycle; mem_to_reg=1 for LD only; then -> FETCH.
REQ-020 alu_op: 00 in LD/SD EXECUTE/MEM, 01 in BEQ EXECUTE, 10 in R/I-ALU EXECUTE/WRITEBACK; alu_src=1 for I-ALU/LD/SD, 0 for R/BEQ.
REQ-021 All controls not listed for a state are 0.
REQ-022 PC update occurs only at the final cycle of an instruction: pc<=pc+(imm<<1) for BEQ with alu_zero=1, else pc<=pc+4; instr_retired=1 that same cycle.
REQ-023 PC arithmetic is modulo 2^XLEN (wraps silently).
REQ-024 Zero-wait latencies: R/I-ALU/SD 4 cycles, LD 5, BEQ 3; each ready-low cycle adds one cycle.
REQ-025 ir and pc are stable from leaving FETCH until the retire cycle.
REQ-026 imem_req and dmem access never assert in the same cycle.

Reset
REQ-027 reset=1 at a clock edge: state<=FETCH, pc<=RESET_PC, ir<=0, trap<=0; all outputs 0 except imem_req, which is 1 in FETCH from the first cycle after reset.
REQ-028 Reset mid-instruction (any state, including pending handshake) aborts it with no retire pulse and no register or memory write.

Configuration
REQ-029 Macro ILLEGAL_TRAP_EN defined: unsupported opcode in EXECUTE -> TRAP; trap=1, all controls 0, pc held, until reset.
REQ-030 Macro absent: unsupported opcode is a NOP, pc<=pc+4 and retire in EXECUTE; trap tied 0; TRAP state unreachable.

Verification
REQ-031 R-type add, imem/dmem ready=1 -> states 0,1,2,4; reg_write one cycle; pc 0->4; retire on cycle 4.
REQ-032 LD with dmem_ready low 3 cycles -> mem_read high 4 cycles, mem_to_reg=1 in WRITEBACK, total 8 cycles.
REQ-033 BEQ, imm=8, alu_zero=1 at pc=0x10 -> pc=0x20 after 3 cycles; alu_zero=0 -> pc=0x14.
REQ-034 pc=2^XLEN-4, non-branch -> pc wraps to 0.
REQ-035 Opcode 1111111 -> with ILLEGAL_TRAP_EN trap=1 and pc frozen; without, pc+4 and retire.
REQ-036 reset asserted during MEM of SD -> mem_write 0 the next cycle, pc=RESET_PC, state=FETCH, no retire.
